prbs16_checker: RTL
===================

// Module: prbs16_checker
// PURPOSE
//  Consumes the 16-bit PRBS word stream from the lfsr generator (one full state word per valid beat).
//  Self-synchronises by seeding a local copy of the same LFSR from the received stream.
//  After lock, flags every word that differs from the locally regenerated sequence and counts errors.
//  Sits directly downstream of the generator, or at the far end of the link under test.
// PARAMETERS
//  LOCK_CNT    4   consecutive matching words after seeding required to declare lock (>=1)
//  LOSS_THRESH 8   consecutive mismatching words while locked that force a return to ST_SEED (>=1)
//  CNT_W       32  width of err_count; saturates at all-ones
// PORTS
//  clk        in   1      single clock; all logic on posedge
//  rst        in   1      synchronous, active-high reset
//  clr_cnt    in   1      synchronous clear of err_count; lock state is unaffected
//  in_valid   in   1      in_data is a new PRBS word this cycle
//  in_data    in   16     received word (generator state)
//  locked     out  1      checker is in ST_LOCKED
//  err_pulse  out  1      one-cycle strobe: the previous valid word mismatched while locked
//  err_count  out  CNT_W  accumulated errors since reset or clr_cnt
// BEHAVIOUR
//  - Next-state function: nxt(s) = {s[14:0], s[15]^s[13]^s[12]^s[10]}. Holds a predicted word `pred`.
//  - Reset (rst=1 at posedge): state=ST_SEED, pred=16'h0000, match/miss counters=0,
//    locked=0, err_pulse=0, err_count=0. Applies mid-operation with no exception.
//  - Nothing advances on cycles with in_valid=0. err_pulse=0 on any cycle that follows in_valid=0.
//  - ST_SEED: a nonzero valid word sets pred=nxt(in_data) and moves to ST_VERIFY with match=0.
//    An all-zero word is the LFSR lock-up state and is ignored (stay in ST_SEED).
//  - ST_VERIFY: if in_data==pred, then pred=nxt(pred) and match++; when match reaches LOCK_CNT,
//    go to ST_LOCKED. Otherwise reseed: pred=nxt(in_data), match=0; a zero word returns to ST_SEED.
//    No errors are counted in ST_VERIFY.
//  - ST_LOCKED: pred=nxt(pred) on every valid word, match or not (free-running reference).
//    On a mismatch: err_pulse=1 in the next cycle, err_count+1 (saturating), miss++.
//    On a match: miss=0. When miss reaches LOSS_THRESH, go to ST_SEED, which reseeds from the next valid word.
//    The word that triggers loss is not used as a seed.
//  - Latency: all outputs are registered. locked rises one cycle after the LOCK_CNT-th matching word is sampled,
//    and falls one cycle after the LOSS_THRESH-th miss.
//  - clr_cnt together with an error in the same cycle: the clear wins (err_count=0), and err_pulse still fires.
//  - err_count at all-ones stays at all-ones; it never wraps.
// CONFIGURATION
//  PRBS_CHK_BITERR_EN defined: err_count adds popcount(in_data ^ pred), i.e. bit errors (0..16 per word),
//    with the addition saturating. err_pulse and loss detection are unchanged (word-level).
//  Undefined: err_count adds 1 per mismatching word.
// STRUCTURE
//  prbs_pkg: LFSR_W=16, SEED_DEFAULT=16'h8001, typedef enum logic[1:0] {ST_SEED,ST_VERIFY,ST_LOCKED} chk_state_t,
//    function lfsr16_next(). The generator will later be refactored to use the same function.
//  Sub-module popcount16 (combinational, 5-bit result) is instantiated only under PRBS_CHK_BITERR_EN.
//  Everything else is flat: FSM, pred register, match/miss counters, saturating err counter.
// TESTING
//  1) Seed from generator 8001,0003,0006,000C,0018 (LOCK_CNT=4) -> locked=1 one cycle after 0018; err_count=0.
//  2) Locked; the word expected as 0x0C00 arrives as 0x0C01 -> err_pulse for one cycle, err_count=1,
//     locked stays 1, and the following words match again.
//  3) Locked; 8 consecutive corrupted words -> locked=0 after the 8th. A new valid stream relocks
//     after 1+LOCK_CNT words; err_count=8.
//  4) In ST_SEED, feed 0x0000 x3, then 8001... -> zeros ignored; lock as in test 1.
//  5) err_count forced near max (CNT_W=4, 15 errors) plus further errors -> count holds 4'hF.
//     Assert clr_cnt together with an error -> 0.
//  6) rst mid-lock, and in_valid gaps of 1-5 cycles between words -> outputs zero after reset;
//     the gaps do not disturb lock or count. With PRBS_CHK_BITERR_EN, the word 0x0003 received as
//     0x00FC -> err_count +=8.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared PRBS16 definitions: LFSR width, default seed, checker states and the next-state function.
package prbs_pkg;

  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] SEED_DEFAULT = 16'h8001;

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } chk_state_t;

  // Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10).
  function automatic logic [LFSR_W-1:0] lfsr16_next(input logic [LFSR_W-1:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/popcount16.sv
// Combinational population count of a 16-bit word (0..16).
module popcount16 (
  input  logic [15:0] data,
  output logic [4:0]  count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < 16; i++) begin
      count = count + 5'(data[i]);
    end
  end

endmodule

// File: rtl/prbs16_checker.sv
// Self-synchronising PRBS16 checker with lock tracking and a saturating error counter.
// Define PRBS_CHK_BITERR_EN to count bit errors per mismatching word instead of word errors.
module prbs16_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_CNT    = 4,
  parameter int LOSS_THRESH = 8,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_cnt,
  input  logic             in_valid,
  input  logic [15:0]      in_data,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count
);

  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W  = $clog2(LOSS_THRESH + 1);
  localparam int SUM_W   = CNT_W + 5;

  chk_state_t        state_reg, state_next;
  logic [LFSR_W-1:0] pred_reg, pred_next;
  logic [MATCH_W-1:0] match_reg, match_next;
  logic [MISS_W-1:0] miss_reg, miss_next;
  logic              locked_reg;
  logic              err_pulse_reg;
  logic [CNT_W-1:0]  err_count_reg, err_count_next;
  logic              err_hit;
  logic              word_match;
  logic [4:0]        err_inc;
  logic [SUM_W-1:0]  err_sum;
  logic [CNT_W-1:0]  err_sat;

  assign word_match = (in_data == pred_reg);

`ifdef PRBS_CHK_BITERR_EN
  logic [15:0] bit_diff;
  logic [4:0]  bit_cnt;
  assign bit_diff = in_data ^ pred_reg;
  popcount16 u_popcount (
    .data  (bit_diff),
    .count (bit_cnt)
  );
  assign err_inc = bit_cnt;
`else
  assign err_inc = 5'd1;
`endif

  // Widen before adding so the carry-out is visible for saturation.
  assign err_sum = SUM_W'(err_count_reg) + SUM_W'(err_inc);
  assign err_sat = (err_sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];

  always_comb begin
    state_next = state_reg;
    pred_next  = pred_reg;
    match_next = match_reg;
    miss_next  = miss_reg;
    err_hit    = 1'b0;
    if (in_valid) begin
      case (state_reg)
        ST_SEED: begin
          if (in_data != '0) begin
            pred_next  = lfsr16_next(in_data);
            match_next = '0;
            state_next = ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (word_match) begin
            pred_next = lfsr16_next(pred_reg);
            if (match_reg == MATCH_W'(LOCK_CNT - 1)) begin
              state_next = ST_LOCKED;
              match_next = '0;
              miss_next  = '0;
            end else begin
              match_next = match_reg + MATCH_W'(1);
            end
          end else if (in_data == '0) begin
            state_next = ST_SEED;
            match_next = '0;
          end else begin
            pred_next  = lfsr16_next(in_data);
            match_next = '0;
          end
        end
        ST_LOCKED: begin
          // Reference free-runs so a corrupted word never disturbs alignment.
          pred_next = lfsr16_next(pred_reg);
          if (!word_match) begin
            err_hit = 1'b1;
            if (miss_reg == MISS_W'(LOSS_THRESH - 1)) begin
              state_next = ST_SEED;
              miss_next  = '0;
            end else begin
              miss_next = miss_reg + MISS_W'(1);
            end
          end else begin
            miss_next = '0;
          end
        end
        default: state_next = ST_SEED;
      endcase
    end
  end

  always_comb begin
    err_count_next = err_count_reg;
    if (clr_cnt)
      err_count_next = '0;
    else if (err_hit)
      err_count_next = err_sat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_SEED;
      pred_reg      <= '0;
      match_reg     <= '0;
      miss_reg      <= '0;
      locked_reg    <= 1'b0;
      err_pulse_reg <= 1'b0;
      err_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      pred_reg      <= pred_next;
      match_reg     <= match_next;
      miss_reg      <= miss_next;
      locked_reg    <= (state_next == ST_LOCKED);
      err_pulse_reg <= err_hit;
      err_count_reg <= err_count_next;
    end
  end

  assign locked    = locked_reg;
  assign err_pulse = err_pulse_reg;
  assign err_count = err_count_reg;

endmodule
